// File: rtl/ccx4_responder.sv
// ccx4_responder
// Off-chip end of the nibble-serial CCX custom-instruction port. The block
// receives two XLEN-bit operands one nibble per cycle, least significant
// nibble first. It waits RESP_DELAY compute cycles, then streams the result
// back one nibble per cycle with a response strobe.
//
// Ports:
//   clk_i       clock, all logic on the rising edge
//   rst_i       synchronous active-high reset
//   ccx_req_i   initiator request, high for NIB consecutive beats
//   ccx_sel_i   operation select (0 ADD, 1 XOR, 2 MINU, 3 MULH16), first beat only
//   ccx_rs_a_i  operand a nibble, LSB nibble first
//   ccx_rs_b_i  operand b nibble, LSB nibble first
//   ccx_res_o   result nibble, LSB nibble first, 0 when not responding
//   ccx_resp_o  high for NIB consecutive cycles while ccx_res_o is valid
//   busy_o      high whenever the responder is not idle
module ccx4_responder #(
    parameter int XLEN       = 32,
    parameter int RESP_DELAY = 1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       ccx_req_i,
    input  logic [1:0] ccx_sel_i,
    input  logic [3:0] ccx_rs_a_i,
    input  logic [3:0] ccx_rs_b_i,
    output logic [3:0] ccx_res_o,
    output logic       ccx_resp_o,
    output logic       busy_o
);
    localparam int NIB = XLEN / 4;
    localparam int CW  = $clog2(NIB + 1);
    localparam int DW  = $clog2(RESP_DELAY + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(NIB - 1);
    localparam logic [DW-1:0] DLY_INIT = DW'(RESP_DELAY);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RECV    = 2'd1,
        S_COMPUTE = 2'd2,
        S_SEND    = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   dly_q, dly_d;
    logic [1:0]      sel_q, sel_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [3:0]      res_q, res_d;
    logic            resp_q, resp_d;
    logic            busy_q, busy_d;
    logic [XLEN-1:0] op_s;
    logic [31:0]     prod_s;

    // Operation datapath on the fully received operands
    always_comb begin
        prod_s = 32'(a_q[15:0]) * 32'(b_q[15:0]);
        op_s   = '0;
        case (sel_q)
            2'd0:    op_s = a_q + b_q;
            2'd1:    op_s = a_q ^ b_q;
            2'd2:    op_s = (a_q < b_q) ? a_q : b_q;
            2'd3:    op_s = XLEN'(prod_s);
            default: op_s = '0;
        endcase
    end

    // Next-state, datapath and registered-output computation
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dly_d    = dly_q;
        sel_d    = sel_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;

        case (state_q)
            S_IDLE: begin
                if (ccx_req_i) begin
                    // Clear stale operand bits so every transaction starts clean
                    a_d      = '0;
                    b_d      = '0;
                    a_d[3:0] = ccx_rs_a_i;
                    b_d[3:0] = ccx_rs_b_i;
                    sel_d    = ccx_sel_i;
                    cnt_d    = CW'(1);
                    state_d  = S_RECV;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RECV: begin
                if (ccx_req_i) begin
                    a_d[{cnt_q, 2'b00} +: 4] = ccx_rs_a_i;
                    b_d[{cnt_q, 2'b00} +: 4] = ccx_rs_b_i;
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        dly_d   = DLY_INIT;
                        state_d = S_COMPUTE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else begin
                    // Request dropped early: abandon the partial transaction
                    a_d     = '0;
                    b_d     = '0;
                    sel_d   = 2'd0;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
            S_COMPUTE: begin
                // Delay counter still holds its load value only in the first cycle
                if (dly_q == DLY_INIT) begin
                    result_d = op_s;
                end else begin
                    result_d = result_q;
                end
                dly_d = dly_q - DW'(1);
                if (dly_q == DW'(1)) begin
                    cnt_d   = '0;
                    state_d = S_SEND;
                end else begin
                    state_d = S_COMPUTE;
                end
            end
            S_SEND: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with it
        resp_d = (state_d == S_SEND);
        busy_d = (state_d != S_IDLE);
        if (resp_d) begin
            res_d = result_d[{cnt_d, 2'b00} +: 4];
        end else begin
            res_d = 4'd0;
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            dly_q    <= '0;
            sel_q    <= 2'd0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            res_q    <= 4'd0;
            resp_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dly_q    <= dly_d;
            sel_q    <= sel_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            res_q    <= res_d;
            resp_q   <= resp_d;
            busy_q   <= busy_d;
        end
    end

    assign ccx_res_o  = res_q;
    assign ccx_resp_o = resp_q;
    assign busy_o     = busy_q;

endmodule
